// File: rtl/double_to_unsigned_int.sv
`default_nettype none
// ============================================================================
//  Module      : double_to_unsigned_int
//  Description : Converts an IEEE-754 binary64 operand to a 64-bit unsigned
//                integer. Truncates toward zero. NaN, negative values and
//                values below 1.0 give zero. Values of 2^64 and above, and
//                +Inf, saturate to all ones. Both sides use a stb/ack
//                handshake, and the conversion is a multi-cycle FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module double_to_unsigned_int (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        CONVERT = 3'd3,
        PUT_Z   = 3'd4
    } state_t;

    localparam logic signed [12:0] c_BIAS      = 13'sd1023;
    localparam logic signed [12:0] c_E_MAXEXP  = 13'sd1024;   // biased exponent 2047
    localparam logic signed [12:0] c_E_LAST    = 13'sd63;     // weight of the mantissa MSB
    localparam logic signed [12:0] c_E_PRELAST = 13'sd62;

    state_t             r_state;
    state_t             w_state_next;

    logic [63:0]        r_a;        // captured operand
    logic               r_s;        // sign
    logic signed [12:0] r_e;        // unbiased exponent, counts up during CONVERT
    logic [63:0]        r_m;        // mantissa, hidden bit aligned at bit 63
    logic [63:0]        r_z;        // result register, held between results
    logic               r_ack;
    logic               r_stb;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_is_nan;
    logic               w_is_zero_den;
    logic               w_to_zero;
    logic               w_to_max;
    logic               w_direct;
    logic [63:0]        w_m_shift;

    assign input_a_ack  = r_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_stb;

    assign w_in_fire  = (r_state == GET_A) && r_ack && input_a_stb;
    assign w_out_fire = (r_state == PUT_Z) && r_stb && output_z_ack;

    // Classification of the unpacked operand, evaluated while in SPECIAL.
    // E=2047 maps to e=1024 and E=0 maps to e=-1023. The fraction is still
    // present in m[62:11] at this point.
    assign w_is_nan      = (r_e == c_E_MAXEXP) && (r_m[62:11] != 52'd0);
    assign w_is_zero_den = (r_e == -c_BIAS);
    assign w_to_zero     = w_is_nan || r_s || w_is_zero_den || (r_e < 13'sd0);
    assign w_to_max      = (r_e > c_E_LAST);

    // e=63 already has the integer in m, so no CONVERT cycle is needed.
    assign w_direct      = w_to_zero || w_to_max || (r_e == c_E_LAST);

    assign w_m_shift     = r_m >> 1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            GET_A: begin
                if (w_in_fire) begin
                    w_state_next = UNPACK;
                end
            end
            UNPACK: begin
                w_state_next = SPECIAL;
            end
            SPECIAL: begin
                if (w_direct) begin
                    w_state_next = PUT_Z;
                end else begin
                    w_state_next = CONVERT;
                end
            end
            CONVERT: begin
                // Leave on the shift that brings e to 63. The following
                // PUT_Z cycle stands in for the e=63 check cycle, which
                // keeps the latency at 3 + (63 - e).
                if (r_e == c_E_PRELAST) begin
                    w_state_next = PUT_Z;
                end
            end
            PUT_Z: begin
                if (w_out_fire) begin
                    w_state_next = GET_A;
                end
            end
            default: begin
                w_state_next = GET_A;
            end
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= 64'd0;
            r_s   <= 1'b0;
            r_e   <= 13'sd0;
            r_m   <= 64'd0;
            r_z   <= 64'd0;
            r_ack <= 1'b0;
            r_stb <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    // ack rises one edge after entry and drops on transfer
                    if (w_in_fire) begin
                        r_a   <= input_a;
                        r_ack <= 1'b0;
                    end else begin
                        r_ack <= 1'b1;
                    end
                end
                UNPACK: begin
                    r_s <= r_a[63];
                    r_e <= $signed({2'b00, r_a[62:52]}) - c_BIAS;
                    r_m <= {1'b1, r_a[51:0], 11'd0};
                end
                SPECIAL: begin
                    if (w_to_zero) begin
                        r_z <= 64'd0;
                    end else if (w_to_max) begin
                        r_z <= {64{1'b1}};
                    end else if (r_e == c_E_LAST) begin
                        r_z <= r_m;
                    end
                end
                CONVERT: begin
                    // Truncating shift: bits falling off the bottom are discarded
                    r_m <= w_m_shift;
                    r_e <= r_e + 13'sd1;
                    if (r_e == c_E_PRELAST) begin
                        r_z <= w_m_shift;
                    end
                end
                PUT_Z: begin
                    // stb rises one edge after entry and drops on transfer
                    if (w_out_fire) begin
                        r_stb <= 1'b0;
                    end else begin
                        r_stb <= 1'b1;
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                    r_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_double_to_unsigned_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_double_to_unsigned_int
//  Description : Directed-vector bench for double_to_unsigned_int
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_double_to_unsigned_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int vectors     = 0;
    int miscompares = 0;
    int overlaps    = 0;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    double_to_unsigned_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Handshake exclusivity watch, sampled away from the active edge
    always @(negedge clk) begin
        if (input_a_ack && output_z_stb) overlaps++;
    end

    // Watchdog
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference: C truncating cast clamped to [0, 2^64-1]
    function automatic logic [63:0] ref_cast(input logic [63:0] x);
        logic [10:0] ex;
        logic [51:0] fr;
        logic [63:0] mm;
        int          sh;
        ex = x[62:52];
        fr = x[51:0];
        if (ex == 11'h7FF && fr != 52'd0) return 64'd0;
        if (x[63])                        return 64'd0;
        if (ex < 11'd1023)                return 64'd0;
        if (ex > 11'd1086)                return c_ONES;
        sh = int'(ex) - 1023;
        mm = {11'd0, 1'b1, fr};
        if (sh >= 52) return mm << (sh - 52);
        return mm >> (52 - sh);
    endfunction

    // Present one operand and return just after its transfer edge
    task automatic send_a(input logic [63:0] v, output bit timeout);
        input_a     = v;
        input_a_stb = 1'b1;
        timeout     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (input_a_ack) begin
                @(posedge clk); #1;
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        input_a_stb = 1'b0;
    endtask

    // Wait for output_z_stb, counting edges, then accept after 'gap' cycles
    task automatic wait_z(input int gap, output logic [63:0] z, output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b1;
        z       = 64'd0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            lat++;
            if (output_z_stb) begin
                timeout = 1'b0;
                break;
            end
        end
        if (!timeout) begin
            repeat (gap) begin @(posedge clk); #1; end
            z            = output_z;
            output_z_ack = 1'b1;
            @(posedge clk); #1;
            output_z_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        input_a      = 64'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (input_a_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", input_a_ack); end
        vectors++;
        if (output_z_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b expected 0", output_z_stb); end
        vectors++;
        if (output_z !== 64'd0) begin miscompares++; $display("FAIL reset_z: got %h expected 0", output_z); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (input_a_ack !== 1'b1) begin miscompares++; $display("FAIL ack_after_reset: got %b expected 1", input_a_ack); end
    endtask

    task automatic test_directed;
        logic [63:0] vin [0:15];
        logic [63:0] vexp[0:15];
        int          vlat[0:15];
        logic [63:0] z;
        int          lat;
        bit          to;
        vin  = '{64'h3FF0000000000000, 64'h43E0000000000000, 64'h400E000000000000, 64'h3FE0000000000000,
                 64'hC014000000000000, 64'h7FF8000000000000, 64'h7FF0000000000000, 64'h43F0000000000000,
                 64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000001, 64'h43EFFFFFFFFFFFFF,
                 64'h4000000000000000, 64'h3FFFFFFFFFFFFFFF, 64'h4330000000000001, 64'hFFF8000000000000};
        vexp = '{64'd1,                64'h8000000000000000, 64'd3,                64'd0,
                 64'd0,                64'd0,                c_ONES,               c_ONES,
                 64'd0,                64'd0,                64'd0,                64'hFFFFFFFFFFFFF800,
                 64'd2,                64'd1,                64'h0010000000000001, 64'd0};
        vlat = '{66, 3, 65, 3, 3, 3, 3, 3, 3, 3, 3, 3, 65, 66, 14, 3};
        for (int i = 0; i < 16; i++) begin
            send_a(vin[i], to);
            if (!to) wait_z(0, z, lat, to);
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL directed_timeout[%0d]: input %h got no result", i, vin[i]);
            end else begin
                vectors++;
                if (z !== vexp[i]) begin
                    miscompares++;
                    $display("FAIL directed_value[%0d]: input %h got %h expected %h", i, vin[i], z, vexp[i]);
                end
                vectors++;
                if (lat != vlat[i]) begin
                    miscompares++;
                    $display("FAIL directed_latency[%0d]: input %h got %0d expected %0d", i, vin[i], lat, vlat[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit to;
        bit seen;
        send_a(64'h400E000000000000, to);
        seen = 1'b0;
        for (int i = 0; i < 200 && !to; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_timeout: got no output_z_stb expected 1");
        end else begin
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                vectors++;
                if (output_z !== 64'd3 || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold[%0d]: got z=%h stb=%b ack=%b expected z=3 stb=1 ack=0",
                             c, output_z, output_z_stb, input_a_ack);
                end
            end
            output_z_ack = 1'b1;
            @(posedge clk); #1;
            output_z_ack = 1'b0;
            vectors++;
            if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_release: got stb=%b ack=%b expected stb=0 ack=0", output_z_stb, input_a_ack);
            end
            @(posedge clk); #1;
            vectors++;
            if (input_a_ack !== 1'b1 || output_z_stb !== 1'b0 || output_z !== 64'd3) begin
                miscompares++;
                $display("FAIL bp_after: got ack=%b stb=%b z=%h expected ack=1 stb=0 z=3",
                         input_a_ack, output_z_stb, output_z);
            end
        end
    endtask

    task automatic test_reset_mid_convert;
        logic [63:0] z;
        int          lat;
        bit          to;
        send_a(64'h3FF0000000000000, to);
        // Convert cycles occupy edges 3..65 after the transfer; stop before edge 12
        repeat (11) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (output_z_stb !== 1'b0 || output_z !== 64'd0 || input_a_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got stb=%b z=%h ack=%b expected 0/0/0", output_z_stb, output_z, input_a_ack);
        end
        send_a(64'h4000000000000000, to);
        if (!to) wait_z(1, z, lat, to);
        vectors++;
        if (to || z !== 64'd2 || lat != 65) begin
            miscompares++;
            $display("FAIL after_abort: got z=%h lat=%0d timeout=%b expected z=2 lat=65", z, lat, to);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] x;
        logic [63:0] z;
        logic [63:0] exp_z;
        int          lat;
        int          sel;
        bit          to;
        int          errs;
        int          done;
        errs = 0;
        done = 0;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            x   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel != 0) begin
                x[62:52] = 11'($urandom_range(1013, 1090));
                if (sel != 1) x[63] = 1'b0;
            end
            exp_z = ref_cast(x);
            send_a(x, to);
            if (!to) wait_z($urandom_range(0, 3), z, lat, to);
            if (to) begin
                $display("FAIL stream_timeout[%0d]: input %h got no result", n, x);
                errs++;
                break;
            end
            done++;
            if (z !== exp_z) begin
                errs++;
                if (errs <= 10) $display("FAIL stream[%0d]: input %h got %h expected %h", n, x, z, exp_z);
            end
        end
        vectors++;
        if (errs != 0 || done != 1000) begin
            miscompares++;
            $display("FAIL stream_total: got %0d errors over %0d results expected 0 over 1000", errs, done);
        end
        vectors++;
        if (overlaps != 0) begin
            miscompares++;
            $display("FAIL ack_stb_overlap: got %0d cycles expected 0", overlaps);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_convert();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/double_to_unsigned_int.md
DOUBLE_TO_UNSIGNED_INT -- requirements
Module: double_to_unsigned_int

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: input_a  input  64  IEEE-754 binary64 operand.
REQ-004 SHALL have ports: input_a_stb  input  1  upstream asserts when input_a is valid.
REQ-005 SHALL have ports: input_a_ack  output  1  block ready to accept input_a.
REQ-006 SHALL have ports: output_z  output  64  unsigned integer result.
REQ-007 SHALL have ports: output_z_stb  output  1  output_z is valid.
REQ-008 SHALL have ports: output_z_ack  input  1  downstream accepts output_z.
REQ-009 SHALL have no parameters; clock is one domain; reset is synchronous and active-high.

Function
REQ-010 SHALL be a multi-cycle FSM with states GET_A, UNPACK, SPECIAL, CONVERT, PUT_Z.
REQ-011 GET_A: SHALL drive input_a_ack=1 from the edge after entry; input transfer occurs on the edge where input_a_stb=1 and input_a_ack=1; on that edge SHALL capture input_a, clear input_a_ack and go to UNPACK.
REQ-012 UNPACK (1 cycle): SHALL split sign s, biased exponent E (11 bits), fraction f (52 bits); SHALL form e = E-1023 as a signed 13-bit value; SHALL load a 64-bit mantissa register m = {1'b1, f, 11'b0}.
REQ-013 SPECIAL (1 cycle), checked in this priority: NaN (E=2047, f!=0) -> z=0; s=1 -> z=0, covering -0, negative finite and -Inf; E=0 (zero or denormal) -> z=0; e<0 -> z=0; e>63 or +Inf -> z=64'hFFFFFFFFFFFFFFFF. Each case SHALL go directly to PUT_Z; otherwise go to CONVERT.
REQ-014 CONVERT: while e<63, each cycle SHALL set m = m>>1 (logical) and e = e+1; when e=63, z=m and go to PUT_Z. Convert cycle count = 63-e, range 0..63.
REQ-015 Rounding SHALL be truncation toward zero; discarded bits SHALL be dropped with no sticky/round logic.
REQ-016 Total latency from input transfer edge to output_z_stb=1 SHALL be 3 + (63-e) cycles for normal in-range inputs and 3 cycles for special cases.
REQ-017 PUT_Z: SHALL drive output_z_stb=1 with output_z stable; on the edge where output_z_stb=1 and output_z_ack=1 SHALL clear output_z_stb and return to GET_A.
REQ-018 output_z SHALL hold its last value after transfer until the next result is loaded.
REQ-019 output_z_ack SHALL be ignored outside PUT_Z; input_a_stb SHALL be ignored outside GET_A, with no second operand buffered.
REQ-020 input_a_ack and output_z_stb SHALL never be 1 in the same cycle.

Reset
REQ-021 When rst=1 at a clock edge: state=GET_A, input_a_ack=0, output_z_stb=0, output_z=0, internal registers cleared.
REQ-022 Reset SHALL take priority in every state; a conversion in progress SHALL be abandoned with no output produced.
REQ-023 The first possible input transfer after rst deasserts SHALL be on the second rising edge, once input_a_ack has risen.

Verification
REQ-024 1.0 (64'h3FF0000000000000) -> output_z=1, output_z_stb rises 66 cycles after the transfer edge.
REQ-025 2^63 (64'h43E0000000000000) -> 64'h8000000000000000 after 3 cycles; 3.75 (64'h400E000000000000) -> 3; 0.5 (64'h3FE0000000000000) -> 0.
REQ-026 -5.0 (64'hC014000000000000) -> 0; NaN 64'h7FF8000000000000 -> 0; +Inf 64'h7FF0000000000000 -> all ones; 2^64 (64'h43F0000000000000) -> all ones.
REQ-027 Backpressure: hold output_z_ack=0 for 20 cycles in PUT_Z -> output_z and output_z_stb stable and input_a_ack=0 throughout; ack=1 -> exactly one transfer, input_a_ack=1 on the following edge.
REQ-028 Reset mid-CONVERT: load 1.0, assert rst on convert cycle 10 -> output_z_stb=0 and output_z=0 after that edge; the next operand, 2.0, converts to 2 with no residue from the aborted conversion.
REQ-029 Stream 1000 random doubles with random stb/ack gaps -> every result equals the C truncating cast clamped to [0, 2^64-1]; no transfers lost or duplicated.
